free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular physical-register free list in the rename/retire loop. It pops up to 3 free PRs per cycle
//  for dispatch/rename and pushes up to 3 Told PRs per cycle released by retire.
//  It rewinds its head on branch-mispredict/exception recovery to the head computed by retire.
//  It exports its head pointer so retire can compute that rewind target.
// PARAMETERS
//  FL_SIZE  32    entries; power of 2; equals #PR - #arch regs
//  PR_W     `PR   physical register index width (6)
//  N_WAY    3     superscalar width; slot 2 = oldest
// PORTS
//  clock          in   1            system clock
//  reset          in   1            synchronous, active-high
//  DispatchEN     in   [2:0]        per-slot request for a new PR
//  free_pr        out  [2:0][PR_W]  PR granted to each requesting slot
//  free_num       out  6            entries available, 0..32
//  RetireEN       in   [2:0]        per-slot Told release from retire
//  Tolds_in       in   [2:0][PR_W]  released PRs
//  BPRecoverEN    in   1            recovery request
//  BPRecoverHead  in   5            head value to restore
//  FreelistHead   out  5            current head pointer
//  fl_error       out  1            over/underflow flag (see CONFIGURATION)
// BEHAVIOUR
//  State: entry[FL_SIZE] of PR_W bits; head, tail (5b, wrap mod 32); count (6b).
//  Reset: entry[i] = i+32; head = 0; tail = 0; count = 32; fl_error = 0.
//   free_num = 32 and FreelistHead = 0 at the first cycle after reset.
//  Allocation (combinational read, registered pop):
//   - Offset k = number of enabled DispatchEN slots above slot i.
//   - Each enabled slot i gets free_pr[i] = entry[(head+k)%32]; disabled slots read 0.
//   - Example: DispatchEN=3'b101 gives slot2 <- entry[head] and slot0 <- entry[head+1].
//   - On the next edge, head += popcount(DispatchEN).
//   - Dispatch must not request more than free_num.
//   - An over-request is clamped: only the first free_num enabled slots (oldest first) pop.
//  Release:
//   - Enabled Tolds_in are written compacted, oldest first, at tail, tail+1, ...
//   - tail += popcount(RetireEN).
//   - Pushes beyond count == 32 are dropped.
//  Same-cycle pop and push:
//   - count_next = count - pops + pushes.
//   - No bypass: a Told pushed this cycle is not grantable until the next cycle.
//  Recovery (BPRecoverEN = 1):
//   - All DispatchEN pops that cycle are ignored.
//   - RetireEN pushes are still performed.
//   - head <= BPRecoverHead.
//   - count <= (tail_next - BPRecoverHead) mod 32, where a result of 0 means 32 (full).
//  Wrap: all pointer arithmetic is modulo FL_SIZE; no separate wrap bit.
//  Reset takes priority over recovery, alloc and release in the same cycle.
//  FreelistHead is the registered head; free_num is the registered count.
// CONFIGURATION
//  FL_CHECK_EN defined:
//   - fl_error is registered and sticky until reset.
//   - It is set when clamping occurs, or when a push is dropped at count == 32.
//   - Simulation $error is issued on the same conditions.
//  FL_CHECK_EN undefined: fl_error is tied 0 and no checks are compiled.
//   Clamping and drop behaviour are unchanged.
// STRUCTURE
//  Shared package: FL_SIZE, the FL pointer typedef (logic [4:0]), and the PR index typedef.
//  Sub-module fl_slot_prefix: 3-bit enable -> per-slot offsets plus popcount.
//   One instance serves dispatch, one serves retire.
//  Top level holds the entry array, pointer/count registers and the recovery math.
// TESTING
//  1. Reset, DispatchEN=111 -> free_pr = {32,33,34}; next cycle free_num=29, FreelistHead=3.
//  2. DispatchEN=101 at head=3 -> free_pr[2]=35, free_pr[0]=36, free_pr[1]=0; head=5.
//  3. Retire Tolds {1,2,3} with RetireEN=111 while allocating 3 at count=3
//     -> grants the old entries; count=3; the new Tolds appear next cycle.
//  4. Allocate to head=30, then DispatchEN=111 -> reads entries 30, 31, 0; head=1 (wrap).
//  5. After 5 allocs (head=5, tail=0): BPRecoverEN with BPRecoverHead=0 and DispatchEN=111
//     -> pops ignored; head=0; free_num=32.
//  6. Define FL_CHECK_EN, count=1, DispatchEN=111 -> only slot2 granted; free_num=0;
//     fl_error=1 until reset.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared types and sizes for the physical-register free list.
package free_list_pkg;
  localparam int FL_SIZE = 32;
  localparam int N_WAY   = 3;
  localparam int PR_W    = 6;

  typedef logic [4:0]      fl_ptr_t;
  typedef logic [PR_W-1:0] pr_idx_t;
  typedef logic [5:0]      fl_cnt_t;
endpackage

// File: rtl/free_list_if.sv
// Rename/retire-facing port bundle of the free list.
// The master side is dispatch/retire and the slave side is the free list.
interface free_list_if;
  import free_list_pkg::*;

  logic    [2:0]      DispatchEN;
  pr_idx_t [2:0]      free_pr;
  fl_cnt_t            free_num;
  logic    [2:0]      RetireEN;
  pr_idx_t [2:0]      Tolds_in;
  logic               BPRecoverEN;
  fl_ptr_t            BPRecoverHead;
  fl_ptr_t            FreelistHead;
  logic               fl_error;

  modport master (output DispatchEN, RetireEN, Tolds_in, BPRecoverEN, BPRecoverHead,
                  input  free_pr, free_num, FreelistHead, fl_error);
  modport slave  (input  DispatchEN, RetireEN, Tolds_in, BPRecoverEN, BPRecoverHead,
                  output free_pr, free_num, FreelistHead, fl_error);
endinterface

// File: rtl/free_list_slot_prefix.sv
// Slot compaction helper: slot 2 is oldest, so each slot's offset is
// the number of enabled slots above it; cnt is the total enabled.
module fl_slot_prefix (
  input  logic [2:0]      en,
  output logic [2:0][1:0] offs,
  output logic [1:0]      cnt
);
  always_comb begin
    offs    = '0;
    offs[2] = 2'd0;
    offs[1] = {1'b0, en[2]};
    offs[0] = 2'({1'b0, en[2]} + {1'b0, en[1]});
    cnt     = 2'({1'b0, en[2]} + {1'b0, en[1]} + {1'b0, en[0]});
  end
endmodule

// File: rtl/free_list.sv
// Circular physical-register free list: 3-wide pop for rename, 3-wide push from retire,
// head rewind on recovery. Define FL_CHECK_EN for a sticky over/underflow flag.
module free_list
  import free_list_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave fl
);
  pr_idx_t [FL_SIZE-1:0] entry_q, entry_d;
  fl_ptr_t               head_q, head_d, tail_q, tail_d;
  fl_cnt_t               count_q, count_d;

  logic [2:0][1:0] d_offs, r_offs;
  logic [1:0]      d_cnt, r_cnt;
  logic [2:0]      pop_ok, push_ok;
  logic [1:0]      pops, eff_pops, pushes;
  fl_cnt_t         avail, room;
  fl_ptr_t         rec_diff;

  fl_slot_prefix u_disp_pfx (.en(fl.DispatchEN), .offs(d_offs), .cnt(d_cnt));
  fl_slot_prefix u_ret_pfx  (.en(fl.RetireEN),   .offs(r_offs), .cnt(r_cnt));

  always_comb begin
    pop_ok   = '0;
    push_ok  = '0;
    fl.free_pr = '0;
    entry_d  = entry_q;
    // Over-requests are clamped oldest-first: only slots whose offset fits in count pop.
    for (int i = 0; i < N_WAY; i++) begin
      pop_ok[i] = fl.DispatchEN[i] && (fl_cnt_t'(d_offs[i]) < count_q);
      if (pop_ok[i]) fl.free_pr[i] = entry_q[fl_ptr_t'(head_q + fl_ptr_t'(d_offs[i]))];
    end
    pops     = (count_q < fl_cnt_t'(d_cnt)) ? count_q[1:0] : d_cnt;
    eff_pops = fl.BPRecoverEN ? 2'd0 : pops;
    avail    = fl_cnt_t'(count_q - fl_cnt_t'(eff_pops));
    room     = fl_cnt_t'(6'd32 - avail);
    for (int i = 0; i < N_WAY; i++) begin
      push_ok[i] = fl.RetireEN[i] && (fl_cnt_t'(r_offs[i]) < room);
      if (push_ok[i]) entry_d[fl_ptr_t'(tail_q + fl_ptr_t'(r_offs[i]))] = fl.Tolds_in[i];
    end
    pushes   = (room < fl_cnt_t'(r_cnt)) ? room[1:0] : r_cnt;
    tail_d   = fl_ptr_t'(tail_q + fl_ptr_t'(pushes));
    rec_diff = fl_ptr_t'(tail_d - fl.BPRecoverHead);
    if (fl.BPRecoverEN) begin
      head_d  = fl.BPRecoverHead;
      // Head == tail after a rewind can only mean every entry is free again.
      count_d = (rec_diff == '0) ? 6'd32 : fl_cnt_t'(rec_diff);
    end else begin
      head_d  = fl_ptr_t'(head_q + fl_ptr_t'(eff_pops));
      count_d = fl_cnt_t'(avail + fl_cnt_t'(pushes));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) entry_q[i] <= pr_idx_t'(i + FL_SIZE);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 6'd32;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign fl.FreelistHead = head_q;
  assign fl.free_num     = count_q;

`ifdef FL_CHECK_EN
  logic clamp, drop, err_q, err_d;

  always_comb begin
    clamp = !fl.BPRecoverEN && (pops != d_cnt);
    drop  = (pushes != r_cnt);
    err_d = err_q | clamp | drop;
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always_ff @(posedge clock) begin
    if (!reset && (clamp || drop))
      $error("free_list: clamp=%0b drop=%0b count=%0d", clamp, drop, count_q);
  end

  assign fl.fl_error = err_q;
`else
  assign fl.fl_error = 1'b0;
`endif
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation, release, wrap, recovery, clamp and drop.
module tb_free_list;
  import free_list_pkg::*;

`ifdef FL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  free_list_if fl ();
  free_list dut (.clock(clock), .reset(reset), .fl(fl));

  always #5 clock = ~clock;

  task automatic drive(input logic [2:0] d, input logic [2:0] r,
                       input int t2, input int t1, input int t0,
                       input logic rec, input int rh);
    fl.DispatchEN    = d;
    fl.RetireEN      = r;
    fl.Tolds_in[2]   = pr_idx_t'(t2);
    fl.Tolds_in[1]   = pr_idx_t'(t1);
    fl.Tolds_in[0]   = pr_idx_t'(t0);
    fl.BPRecoverEN   = rec;
    fl.BPRecoverHead = fl_ptr_t'(rh);
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
    step();
    reset = 1'b0;
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
      step();
    end
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fl.free_num !== 6'd32) begin errors++; $display("FAIL rst_num got %0d want 32", fl.free_num); end
    checks++; if (fl.FreelistHead !== 5'd0) begin errors++; $display("FAIL rst_head got %0d want 0", fl.FreelistHead); end
    checks++; if (fl.fl_error !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", fl.fl_error); end
  endtask

  task automatic test_alloc3();
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr[2] !== 6'd32) begin errors++; $display("FAIL a3_pr2 got %0d want 32", fl.free_pr[2]); end
    checks++; if (fl.free_pr[1] !== 6'd33) begin errors++; $display("FAIL a3_pr1 got %0d want 33", fl.free_pr[1]); end
    checks++; if (fl.free_pr[0] !== 6'd34) begin errors++; $display("FAIL a3_pr0 got %0d want 34", fl.free_pr[0]); end
    step();
    checks++; if (fl.free_num !== 6'd29) begin errors++; $display("FAIL a3_num got %0d want 29", fl.free_num); end
    checks++; if (fl.FreelistHead !== 5'd3) begin errors++; $display("FAIL a3_head got %0d want 3", fl.FreelistHead); end
  endtask

  task automatic test_skip_slot();
    drive(3'b101, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr[2] !== 6'd35) begin errors++; $display("FAIL sk_pr2 got %0d want 35", fl.free_pr[2]); end
    checks++; if (fl.free_pr[1] !== 6'd0)  begin errors++; $display("FAIL sk_pr1 got %0d want 0", fl.free_pr[1]); end
    checks++; if (fl.free_pr[0] !== 6'd36) begin errors++; $display("FAIL sk_pr0 got %0d want 36", fl.free_pr[0]); end
    step();
    checks++; if (fl.FreelistHead !== 5'd5) begin errors++; $display("FAIL sk_head got %0d want 5", fl.FreelistHead); end
    checks++; if (fl.free_num !== 6'd27) begin errors++; $display("FAIL sk_num got %0d want 27", fl.free_num); end
  endtask

  task automatic test_same_cycle();
    alloc_n(8);
    checks++; if (fl.FreelistHead !== 5'd29) begin errors++; $display("FAIL sc_head0 got %0d want 29", fl.FreelistHead); end
    checks++; if (fl.free_num !== 6'd3) begin errors++; $display("FAIL sc_num0 got %0d want 3", fl.free_num); end
    drive(3'b111, 3'b111, 1, 2, 3, 1'b0, 0);
    checks++; if (fl.free_pr !== {6'd61, 6'd62, 6'd63}) begin errors++; $display("FAIL sc_old got %h want 61,62,63", fl.free_pr); end
    step();
    checks++; if (fl.free_num !== 6'd3) begin errors++; $display("FAIL sc_num1 got %0d want 3", fl.free_num); end
    checks++; if (fl.FreelistHead !== 5'd0) begin errors++; $display("FAIL sc_head1 got %0d want 0", fl.FreelistHead); end
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr !== {6'd1, 6'd2, 6'd3}) begin errors++; $display("FAIL sc_new got %h want 1,2,3", fl.free_pr); end
    step();
    checks++; if (fl.free_num !== 6'd0) begin errors++; $display("FAIL sc_num2 got %0d want 0", fl.free_num); end
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_n(10);
    checks++; if (fl.FreelistHead !== 5'd30) begin errors++; $display("FAIL wr_head0 got %0d want 30", fl.FreelistHead); end
    drive(3'b000, 3'b111, 10, 11, 12, 1'b0, 0);
    step();
    checks++; if (fl.free_num !== 6'd5) begin errors++; $display("FAIL wr_num0 got %0d want 5", fl.free_num); end
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr !== {6'd62, 6'd63, 6'd10}) begin errors++; $display("FAIL wr_pr got %h want 62,63,10", fl.free_pr); end
    step();
    checks++; if (fl.FreelistHead !== 5'd1) begin errors++; $display("FAIL wr_head1 got %0d want 1", fl.FreelistHead); end
    checks++; if (fl.free_num !== 6'd2) begin errors++; $display("FAIL wr_num1 got %0d want 2", fl.free_num); end
  endtask

  task automatic test_recover();
    do_reset();
    alloc_n(1);
    drive(3'b011, 3'b000, 0, 0, 0, 1'b0, 0);
    step();
    checks++; if (fl.FreelistHead !== 5'd5) begin errors++; $display("FAIL rc_head0 got %0d want 5", fl.FreelistHead); end
    drive(3'b111, 3'b000, 0, 0, 0, 1'b1, 0);
    step();
    checks++; if (fl.FreelistHead !== 5'd0) begin errors++; $display("FAIL rc_head1 got %0d want 0", fl.FreelistHead); end
    checks++; if (fl.free_num !== 6'd32) begin errors++; $display("FAIL rc_num1 got %0d want 32", fl.free_num); end
    // Rewind with a concurrent push: tail moves 0->1, head to 2, count = (1-2) mod 32.
    do_reset();
    alloc_n(2);
    drive(3'b111, 3'b100, 40, 0, 0, 1'b1, 2);
    step();
    checks++; if (fl.FreelistHead !== 5'd2) begin errors++; $display("FAIL rc_head2 got %0d want 2", fl.FreelistHead); end
    checks++; if (fl.free_num !== 6'd31) begin errors++; $display("FAIL rc_num2 got %0d want 31", fl.free_num); end
    drive(3'b100, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr[2] !== 6'd34) begin errors++; $display("FAIL rc_pr got %0d want 34", fl.free_pr[2]); end
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_clamp();
    do_reset();
    alloc_n(10);
    drive(3'b100, 3'b000, 0, 0, 0, 1'b0, 0);
    step();
    checks++; if (fl.free_num !== 6'd1) begin errors++; $display("FAIL cl_num0 got %0d want 1", fl.free_num); end
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr !== {6'd63, 6'd0, 6'd0}) begin errors++; $display("FAIL cl_pr got %h want 63,0,0", fl.free_pr); end
    step();
    checks++; if (fl.free_num !== 6'd0) begin errors++; $display("FAIL cl_num1 got %0d want 0", fl.free_num); end
    checks++; if (fl.FreelistHead !== 5'd0) begin errors++; $display("FAIL cl_head got %0d want 0", fl.FreelistHead); end
    checks++; if (fl.fl_error !== CHK) begin errors++; $display("FAIL cl_err got %0b want %0b", fl.fl_error, CHK); end
    drive(3'b100, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr[2] !== 6'd0) begin errors++; $display("FAIL cl_empty got %0d want 0", fl.free_pr[2]); end
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 0);
    step();
    checks++; if (fl.fl_error !== CHK) begin errors++; $display("FAIL cl_sticky got %0b want %0b", fl.fl_error, CHK); end
    checks++; if (fl.free_num !== 6'd0) begin errors++; $display("FAIL cl_num2 got %0d want 0", fl.free_num); end
  endtask

  task automatic test_drop();
    do_reset();
    checks++; if (fl.fl_error !== 1'b0) begin errors++; $display("FAIL dr_clr got %0b want 0", fl.fl_error); end
    drive(3'b000, 3'b111, 5, 6, 7, 1'b0, 0);
    step();
    checks++; if (fl.free_num !== 6'd32) begin errors++; $display("FAIL dr_num got %0d want 32", fl.free_num); end
    checks++; if (fl.fl_error !== CHK) begin errors++; $display("FAIL dr_err got %0b want %0b", fl.fl_error, CHK); end
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, 0);
    checks++; if (fl.free_pr !== {6'd32, 6'd33, 6'd34}) begin errors++; $display("FAIL dr_keep got %h want 32,33,34", fl.free_pr); end
    // Partial drop: one free slot, three pushes -> count saturates at 32.
    do_reset();
    drive(3'b100, 3'b000, 0, 0, 0, 1'b0, 0);
    step();
    drive(3'b000, 3'b111, 5, 6, 7, 1'b0, 0);
    step();
    checks++; if (fl.free_num !== 6'd32) begin errors++; $display("FAIL dr_part got %0d want 32", fl.free_num); end
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    drive(3'b000, 3'b000, 0, 0, 0, 1'b0, 0);
    test_reset();
    test_alloc3();
    test_skip_slot();
    test_same_cycle();
    test_wrap();
    test_recover();
    test_clamp();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
